// File: rtl/cam_pkg.sv
// Shared constants, FSM encoding and pixel conversion for the camera frame writer.
package cam_pkg;

  localparam int c_img_cols    = 160;
  localparam int c_img_rows    = 120;
  localparam int c_img_pxls    = c_img_cols * c_img_rows;
  localparam int c_nb_img_pxls = 15;
  localparam int c_nb_buf      = 12;
  localparam int c_dec_log2    = 1;
  localparam int c_nb_src_cnt  = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } cam_state_t;

  // RGB565 arrives as hi={R5,G[5:3]}, lo={G[2:0],B5}; keep the top 4 bits of each colour.
  function automatic logic [c_nb_buf-1:0] rgb565_to_rgb444(input logic [7:0] hi,
                                                           input logic [7:0] lo);
    logic unused_bits;
    unused_bits = ^{hi[3], lo[6:5], lo[0]};
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

endpackage

// File: rtl/cam_frame_writer_if.sv
// Camera byte stream in, frame buffer write port out.
interface cam_frame_writer_if import cam_pkg::*; ();

  // No back-pressure on either side: byte_valid_i is a one-cycle strobe the writer must
  // take when href_i is high, and wea is a one-cycle write the buffer must accept.
  logic                     vsync_i;
  logic                     href_i;
  logic                     byte_valid_i;
  logic [7:0]               byte_i;
  logic                     wea;
  logic [c_nb_img_pxls-1:0] addr;
  logic [c_nb_buf-1:0]      data;

  modport master (
    output vsync_i, href_i, byte_valid_i, byte_i,
    input  wea, addr, data
  );

  modport slave (
    input  vsync_i, href_i, byte_valid_i, byte_i,
    output wea, addr, data
  );

endinterface

// File: rtl/cam_pxl_assembler.sv
// Pairs camera bytes into RGB565 pixels and emits a registered RGB444 write one cycle later.
module cam_pxl_assembler import cam_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                accept,
  input  logic                keep,
  input  logic [7:0]          byte_i,
  output logic                done,
  output logic                pxl_valid,
  output logic [c_nb_buf-1:0] pxl
);

  logic       phase;
  logic       phase_eff;
  logic [7:0] hi_q;

  // A line edge in the same cycle as a byte makes that byte the hi half.
  assign phase_eff = phase & ~clr;
  assign done      = accept & phase_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= 1'b0;
      hi_q      <= '0;
      pxl_valid <= 1'b0;
      pxl       <= '0;
    end else begin
      pxl_valid <= done & keep;
      if (done & keep) pxl <= rgb565_to_rgb444(hi_q, byte_i);
      if (accept & ~phase_eff) hi_q <= byte_i;
      phase <= phase_eff ^ accept;
    end
  end

endmodule

// File: rtl/cam_frame_writer.sv
// Frame FSM, source counters, decimation and end-of-frame check around the pixel assembler.
module cam_frame_writer import cam_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  cam_frame_writer_if.slave  cam,
  output logic               capture_newframe,
  output logic               frame_err_o,
  output logic               busy_o,
  output cam_state_t         state_o
);

  localparam logic [c_nb_src_cnt-1:0] c_src_cols = c_nb_src_cnt'(c_img_cols << c_dec_log2);
  localparam logic [c_nb_src_cnt-1:0] c_src_rows = c_nb_src_cnt'(c_img_rows << c_dec_log2);
  localparam logic [c_nb_src_cnt-1:0] c_dec_mask = c_nb_src_cnt'((1 << c_dec_log2) - 1);
  localparam logic [c_nb_img_pxls-1:0] c_pxls_max = c_nb_img_pxls'(c_img_pxls);
  localparam logic [c_nb_img_pxls:0]   c_fin_full = (c_nb_img_pxls+1)'(c_img_pxls);

  cam_state_t               state, state_nxt;
  logic                     vsync_q, href_q, gate;
  logic [c_nb_src_cnt-1:0]  src_col, src_row;
  logic [c_nb_img_pxls-1:0] wr_cnt;
  logic                     vsync_rise, vsync_fall, href_rise, href_fall, line_ok;
  logic                     in_frame, frame_start, frame_end;
  logic                     byte_acc, line_clr, pxl_done, wr_keep, pxl_valid;
  logic [c_nb_buf-1:0]      pxl;
  logic [c_nb_img_pxls:0]   fin_cnt;

  function automatic logic [c_nb_src_cnt-1:0] sat_inc(input logic [c_nb_src_cnt-1:0] x);
    return (x == '1) ? x : x + c_nb_src_cnt'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= cam.vsync_i;
      href_q  <= cam.href_i;
    end
  end

  assign vsync_rise = cam.vsync_i & ~vsync_q;
  assign vsync_fall = ~cam.vsync_i & vsync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (cam.vsync_i) state_nxt = ST_SYNC;
      ST_SYNC:   if (vsync_fall)  state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (vsync_rise)  state_nxt = ST_SYNC;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_frame    = (state == ST_ACTIVE);
    frame_start = (state == ST_SYNC) & vsync_fall;
    frame_end   = in_frame & vsync_rise;
    busy_o      = in_frame & gate;
  end

  assign state_o = state;

  // Line edges during vertical blanking are ignored.
  assign line_ok   = in_frame & ~cam.vsync_i;
  assign href_rise = line_ok & cam.href_i & ~href_q;
  assign href_fall = line_ok & ~cam.href_i & href_q;
  assign byte_acc  = in_frame & cam.href_i & cam.byte_valid_i;
  assign line_clr  = frame_start | href_rise | href_fall;

  assign wr_keep = gate
                 & ((src_col & c_dec_mask) == '0)
                 & ((src_row & c_dec_mask) == '0)
                 & (src_col < c_src_cols)
                 & (src_row < c_src_rows)
                 & (wr_cnt < c_pxls_max);

  // Count at the vsync edge includes a write still in flight and one completing right now.
  assign fin_cnt = {1'b0, wr_cnt}
                 + (c_nb_img_pxls+1)'(pxl_valid)
                 + (c_nb_img_pxls+1)'(pxl_done & wr_keep);

  cam_pxl_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (line_clr),
    .accept    (byte_acc),
    .keep      (wr_keep),
    .byte_i    (cam.byte_i),
    .done      (pxl_done),
    .pxl_valid (pxl_valid),
    .pxl       (pxl)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate             <= 1'b0;
      src_col          <= '0;
      src_row          <= '0;
      wr_cnt           <= '0;
      capture_newframe <= 1'b0;
      frame_err_o      <= 1'b0;
    end else begin
      if (frame_start) gate <= enable_i;

      if (frame_start | href_rise) src_col <= '0;
      else if (pxl_done)           src_col <= sat_inc(src_col);

      if (frame_start)    src_row <= '0;
      else if (href_fall) src_row <= sat_inc(src_row);

      if (frame_start)    wr_cnt <= '0;
      else if (pxl_valid) wr_cnt <= wr_cnt + c_nb_img_pxls'(1);

      capture_newframe <= frame_end & gate & (fin_cnt == c_fin_full);
      frame_err_o      <= frame_end & gate & (fin_cnt != c_fin_full);
    end
  end

  assign cam.wea  = pxl_valid;
  assign cam.addr = wr_cnt;
  assign cam.data = pxl;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Randomized bench for cam_frame_writer with a frame-level reference model and scoreboard.
module tb_cam_frame_writer;
  import cam_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_i = 1'b0;
  logic       capture_newframe, frame_err_o, busy_o;
  cam_state_t state_o;

  cam_frame_writer_if bus ();

  cam_frame_writer dut (
    .clk              (clk),
    .rst              (rst),
    .enable_i         (enable_i),
    .cam              (bus),
    .capture_newframe (capture_newframe),
    .frame_err_o      (frame_err_o),
    .busy_o           (busy_o),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #980000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int          total = 0;
  int          bad = 0;
  logic [26:0] exp_q[$];
  logic [1:0]  ev_q[$];
  logic [26:0] obs_q[$];
  int          obs_cap = 0;
  int          obs_err = 0;
  int          m_cnt = 0;
  bit          m_gate = 0;
  bit          m_active = 0;
  int          pin_r = -1;
  int          pin_c = -1;
  logic [7:0]  pin_hi = 8'h00;
  logic [7:0]  pin_lo = 8'h00;
  logic [26:0] w_exp;
  logic [1:0]  e_exp;
  logic [26:0] obs_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to444(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

  // Scoreboard: every write and every end-of-frame pulse must match the model in order.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.wea) begin
        obs_q.push_back({bus.addr, bus.data});
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wea_unexpected actual=%0d/%03h required=no_write", bus.addr, bus.data);
        end else begin
          w_exp = exp_q.pop_front();
          chk("write", 32'({bus.addr, bus.data}), 32'(w_exp));
        end
      end
      if (capture_newframe || frame_err_o) begin
        if (capture_newframe) obs_cap++;
        if (frame_err_o) obs_err++;
        if (ev_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pulse_unexpected actual=%0b%0b required=none", capture_newframe, frame_err_o);
        end else begin
          e_exp = ev_q.pop_front();
          chk("frame_pulse", 32'({capture_newframe, frame_err_o}), 32'(e_exp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pixel(input int r, input int c, input logic [7:0] hi, input logic [7:0] lo);
    if (m_active && m_gate && (r % 2 == 0) && (c % 2 == 0) && c < 320 && r < 240 && m_cnt < 19200) begin
      exp_q.push_back({15'(m_cnt), to444(hi, lo)});
      m_cnt++;
    end
  endtask

  task automatic raise_vsync();
    if (m_active && m_gate) ev_q.push_back((m_cnt == 19200) ? 2'b10 : 2'b01);
    m_active = 0;
    bus.vsync_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bus.byte_valid_i = 1'b1;
    bus.byte_i = b;
    tick();
    bus.byte_valid_i = 1'b0;
    if (gaps && $urandom_range(0, 2) == 0) tick();
  endtask

  task automatic send_line(input int r, input int npix, input bit odd, input bit gaps,
                           input bit full, input bit vs_end);
    logic [7:0] hi, lo;
    bit         last;
    bus.href_i = 1'b1;
    if ((npix == 0 && !odd) || (gaps && $urandom_range(0, 1) == 1)) tick();
    for (int c = 0; c < npix; c++) begin
      if (full) begin
        hi = 8'hF8;
        lo = 8'h1F;
      end else begin
        hi = 8'($urandom);
        lo = 8'($urandom);
      end
      if (r == pin_r && c == pin_c) begin
        hi = pin_hi;
        lo = pin_lo;
      end
      last = vs_end && (c == npix - 1);
      model_pixel(r, c, hi, lo);
      send_byte(hi, gaps);
      if (last) raise_vsync();
      send_byte(lo, gaps && !last);
    end
    if (odd && !vs_end) send_byte(8'($urandom), gaps);
    bus.href_i = 1'b0;
    tick();
    tick();
    if (gaps) begin
      bus.byte_valid_i = 1'b1;
      bus.byte_i = 8'($urandom);
      tick();
      bus.byte_valid_i = 1'b0;
    end
  endtask

  task automatic frame_begin(input bit en);
    bus.vsync_i = 1'b1;
    repeat (3) tick();
    enable_i = en;
    bus.vsync_i = 1'b0;
    m_gate = en;
    m_active = 1;
    m_cnt = 0;
    obs_q.delete();
    obs_cap = 0;
    obs_err = 0;
    tick();
    tick();
  endtask

  task automatic frame_end();
    if (!bus.vsync_i) raise_vsync();
    repeat (4) tick();
    for (int i = 0; i < 12 && (exp_q.size() != 0 || ev_q.size() != 0); i++) tick();
    chk("drain", 32'(exp_q.size() + ev_q.size()), 32'd0);
  endtask

  initial begin
    bus.vsync_i = 1'b0;
    bus.href_i = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'h00;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wea", 32'(bus.wea), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_cap", 32'(capture_newframe), 32'd0);
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    rst = 1'b1;
    tick();

    // Pinned pixel: (2,0) lands at addr 1; (1,0) and (0,1) are decimated away.
    frame_begin(1'b1);
    chk("busy_on", 32'(busy_o), 32'd1);
    chk("state_active", 32'(state_o), 32'(ST_ACTIVE));
    pin_r = 0; pin_c = 2; pin_hi = 8'h07; pin_lo = 8'hE0;
    send_line(0, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    pin_r = -1;
    send_line(1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_line(2, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    frame_end();
    chk("pin_writes", 32'(obs_q.size()), 32'd3);
    obs_w = obs_q[1];
    chk("pin_addr1", 32'(obs_w), 32'({15'd1, 12'h0F0}));
    chk("pin_err", 32'(obs_err), 32'd1);
    chk("pin_cap", 32'(obs_cap), 32'd0);

    // 330-pixel lines with a trailing odd byte.
    frame_begin(1'b1);
    send_line(0, 330, 1'b1, 1'b0, 1'b0, 1'b0);
    send_line(1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    send_line(2, 330, 1'b1, 1'b0, 1'b0, 1'b0);
    frame_end();
    chk("long_writes", 32'(obs_q.size()), 32'd320);
    obs_w = obs_q[160];
    chk("long_line2_addr", 32'(obs_w[26:12]), 32'd160);

    // Enable low at frame start, raised mid-frame.
    frame_begin(1'b0);
    chk("busy_off", 32'(busy_o), 32'd0);
    send_line(0, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    enable_i = 1'b1;
    for (int r = 1; r < 4; r++) send_line(r, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    frame_end();
    chk("gated_writes", 32'(obs_q.size()), 32'd0);
    chk("gated_pulses", 32'(obs_cap + obs_err), 32'd0);

    for (int k = 0; k < 3; k++) begin
      frame_begin($urandom_range(0, 3) != 0);
      for (int r = 0; r < int'($urandom_range(2, 6)); r++)
        send_line(r, $urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      frame_end();
    end

    // Reset while row 100 is active.
    frame_begin(1'b1);
    for (int r = 0; r < 100; r++)
      send_line(r, (r % 2 == 0) ? 2 : 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    bus.href_i = 1'b1;
    tick();
    tick();
    chk("pre_reset_drain", 32'(exp_q.size()), 32'd0);
    chk("pre_reset_addr", 32'(bus.addr), 32'd50);
    rst = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(bus.addr), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_state", 32'(state_o), 32'(ST_IDLE));
    m_active = 0;
    m_gate = 0;
    repeat (2) tick();
    rst = 1'b1;
    bus.href_i = 1'b0;
    tick();
    obs_q.delete();
    for (int r = 0; r < 3; r++) send_line(r, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_writes", 32'(obs_q.size()), 32'd0);
    chk("post_rst_state", 32'(state_o), 32'(ST_IDLE));

    // Full frame; last kept pixel completes in the same cycle vsync rises.
    frame_begin(1'b1);
    for (int r = 0; r <= 238; r++) begin
      if (r % 2 == 0) send_line(r, (r == 238) ? 319 : 320, 1'b0, 1'b0, 1'b1, r == 238);
      else            send_line(r, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    frame_end();
    chk("full_writes", 32'(obs_q.size()), 32'd19200);
    obs_w = obs_q[0];
    chk("full_first", 32'(obs_w), 32'({15'd0, 12'hF0F}));
    obs_w = obs_q[19199];
    chk("full_last", 32'(obs_w), 32'({15'd19199, 12'hF0F}));
    chk("full_cap", 32'(obs_cap), 32'd1);
    chk("full_err", 32'(obs_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
